// File: rtl/si_pkg.sv
// Shared constants and FSM state type for the two-stage serial transfer link.
package si_pkg;

  localparam int unsigned FRAME_BITS = 21;
  localparam int unsigned IDX_BITS   = 3;
  localparam int unsigned DW         = 18;
  localparam int unsigned FRAMES     = 8;
  localparam int unsigned RB1_DEPTH  = 32;
  localparam int unsigned RB2_DEPTH  = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sync_ram.sv
// Single-port memory with synchronous read; Q shows CELL[A] one cycle after A.
module sync_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AWID  = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             WENn,
  input  logic [AWID-1:0]  A,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] CELL [DEPTH];

  always_ff @(posedge CLK) begin
    if (!WENn) begin
      CELL[A] <= D;
    end
    Q <= CELL[A];
  end

endmodule

// File: rtl/s1_serial_sender.sv
// S1 sender: reads the 18-byte RB1 image once after reset, transposes it into
// eight 18-bit words and streams each as a 21-bit {index, word} frame on sen/sd.
module s1_serial_sender #(
  parameter int unsigned FRAMES = 8,
  parameter int unsigned DW     = 18,
  parameter int unsigned AW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  output logic          RB1_RW,
  output logic [AW-1:0] RB1_A,
  output logic [7:0]    RB1_D,
  input  logic [7:0]    RB1_Q,
  output logic          sen,
  output logic          sd
);

  import si_pkg::*;

  localparam int unsigned FB = IDX_BITS + DW;
  localparam int unsigned CW = CNT_W;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IDX_BITS-1:0]       idx_q, idx_d;
  logic [DW-1:0][BYTE_W-1:0] buf_q, buf_d;
  logic [FB-1:0]             shreg_q, shreg_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic                      sen_q, sen_d;
  logic                      sd_q, sd_d;
  logic                      rw_q;
  logic [BYTE_W-1:0]         wd_q;

  logic [DW-1:0][BYTE_W-1:0] img_c;
  logic [CW-1:0]             cap_idx_c;
  logic [IDX_BITS-1:0]       fidx_c;
  logic [DW-1:0]             word_c;
  logic [FB-1:0]             frame_c;

  // Image including the byte arriving this cycle, so frame 0 can launch
  // on the same edge that captures the last RB1 byte.
  always_comb begin
    img_c     = buf_q;
    cap_idx_c = cnt_q - CW'(1);
    if (state_q == LOAD && cnt_q != '0) begin
      img_c[cap_idx_c] = RB1_Q;
    end
  end

  // Transposed word for the frame about to start: bit (DW-1-k) = byte k, bit n.
  always_comb begin
    fidx_c = (state_q == GAP) ? idx_q + IDX_BITS'(1) : idx_q;
    word_c = '0;
    for (int k = 0; k < int'(DW); k++) begin
      word_c[DW-1-k] = img_c[k][fidx_c];
    end
    frame_c = {fidx_c, word_c};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    shreg_d = shreg_q;
    addr_d  = addr_q;
    sen_d   = sen_q;
    sd_d    = sd_q;

    case (state_q)
      IDLE: begin
        state_d = LOAD;
        cnt_d   = '0;
        addr_d  = '0;
      end

      // Address k is presented in cycle k, its byte captured in cycle k+1.
      LOAD: begin
        buf_d = img_c;
        if (cnt_q < CW'(DW - 1)) begin
          addr_d = addr_q + AW'(1);
        end
        if (cnt_q == CW'(DW)) begin
          state_d = SEND;
          cnt_d   = '0;
          addr_d  = '0;
          sen_d   = 1'b0;
          sd_d    = frame_c[FB-1];
          shreg_d = {frame_c[FB-2:0], 1'b0};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SEND: begin
        if (cnt_q == CW'(FB - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          sen_d   = 1'b1;
          sd_d    = 1'b0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          sd_d    = shreg_q[FB-1];
          shreg_d = {shreg_q[FB-2:0], 1'b0};
        end
      end

      GAP: begin
        if (idx_q == IDX_BITS'(FRAMES - 1)) begin
          state_d = DONE;
        end else begin
          state_d = SEND;
          idx_d   = fidx_c;
          sen_d   = 1'b0;
          sd_d    = frame_c[FB-1];
          shreg_d = {frame_c[FB-2:0], 1'b0};
        end
      end

      DONE: begin
        sen_d = 1'b1;
        sd_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      shreg_q <= '0;
      addr_q  <= '0;
      sen_q   <= 1'b1;
      sd_q    <= 1'b0;
      rw_q    <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      shreg_q <= shreg_d;
      addr_q  <= addr_d;
      sen_q   <= sen_d;
      sd_q    <= sd_d;
      rw_q    <= 1'b1;
      wd_q    <= '0;
    end
  end

  assign RB1_RW = rw_q;
  assign RB1_A  = addr_q;
  assign RB1_D  = wd_q;
  assign sen    = sen_q;
  assign sd     = sd_q;

endmodule

// File: tb/tb_s1_serial_sender.sv
// Bench for s1_serial_sender: RB1 and RB2 memory models, a frame receiver
// feeding a scoreboard, and a table of images with their transposed words.
module tb_s1_serial_sender;

  logic        clk;
  logic        rst;
  logic        RB1_RW;
  logic [4:0]  RB1_A;
  logic [7:0]  RB1_D;
  logic [7:0]  RB1_Q;
  logic        sen;
  logic        sd;

  logic        tb_load;
  logic        tb_wen;
  logic [4:0]  tb_a;
  logic [7:0]  tb_d;
  logic        rb1_wen;
  logic [4:0]  rb1_a;
  logic [7:0]  rb1_d;

  logic        rb2_wen;
  logic [2:0]  rb2_wa;
  logic [17:0] rb2_wd;
  logic [2:0]  rb2_rd_a;
  logic [2:0]  rb2_a;
  logic [17:0] rb2_q;

  int          n_cmp;
  int          n_bad;
  int          low_cnt;
  int          high_cnt;
  int          frames_seen;
  int          addr_err;
  int          ctl_err;
  logic [20:0] rx;
  logic [20:0] exp_q [$];

  typedef struct packed {
    logic [17:0][7:0] img;
    logic [7:0][17:0] exp;
  } vec_t;

  vec_t vecs [5];

  s1_serial_sender dut (
    .clk    (clk),
    .rst    (rst),
    .RB1_RW (RB1_RW),
    .RB1_A  (RB1_A),
    .RB1_D  (RB1_D),
    .RB1_Q  (RB1_Q),
    .sen    (sen),
    .sd     (sd)
  );

  assign rb1_wen = tb_load ? tb_wen : RB1_RW;
  assign rb1_a   = tb_load ? tb_a   : RB1_A;
  assign rb1_d   = tb_load ? tb_d   : RB1_D;

  sync_ram #(.DEPTH(32), .WIDTH(8)) rb1 (
    .CLK  (clk),
    .WENn (rb1_wen),
    .A    (rb1_a),
    .D    (rb1_d),
    .Q    (RB1_Q)
  );

  assign rb2_a = rb2_wen ? rb2_rd_a : rb2_wa;

  sync_ram #(.DEPTH(8), .WIDTH(18)) rb2 (
    .CLK  (clk),
    .WENn (rb2_wen),
    .A    (rb2_a),
    .D    (rb2_wd),
    .Q    (rb2_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0][17:0] transpose(input logic [17:0][7:0] img);
    logic [7:0][17:0] t;
    t = '0;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 18; k++) begin
        t[n][17-k] = img[k][n];
      end
    end
    return t;
  endfunction

  // S2-style receiver: samples sd while sen is low, writes each 21-bit frame to RB2.
  always @(negedge clk) begin
    rb2_wen = 1'b1;
    if (!rst) begin
      low_cnt     = 0;
      high_cnt    = 0;
      frames_seen = 0;
      rx          = '0;
    end else begin
      if (RB1_A > 5'd17) addr_err++;
      if (RB1_RW !== 1'b1 || RB1_D !== 8'h00) ctl_err++;
      if (sen === 1'b0) begin
        if (low_cnt == 0 && frames_seen > 0) chk("gap_len", 32'(high_cnt), 32'd1);
        rx       = {rx[19:0], sd};
        low_cnt  = low_cnt + 1;
        high_cnt = 0;
        if (low_cnt == 21) begin
          chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            chk("frame_data", 32'(rx), 32'(exp_q.pop_front()));
          end
          rb2_wen     = 1'b0;
          rb2_wa      = rx[20:18];
          rb2_wd      = rx[17:0];
          frames_seen = frames_seen + 1;
        end
      end else begin
        if (low_cnt != 0) chk("burst_len", 32'(low_cnt), 32'd21);
        low_cnt  = 0;
        high_cnt = high_cnt + 1;
      end
    end
  end

  task automatic load_img(input logic [17:0][7:0] img);
    @(negedge clk);
    rst     = 1'b0;
    tb_load = 1'b1;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      tb_a   = 5'(a);
      tb_d   = (a < 18) ? img[a] : 8'hC3;
      tb_wen = 1'b0;
    end
    @(negedge clk);
    tb_wen  = 1'b1;
    tb_load = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0][17:0] ew);
    exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back({3'(n), ew[n]});
    end
  endtask

  task automatic run_xfer(input logic [7:0][17:0] ew);
    int cyc;
    int bad;
    bit seen;
    @(negedge clk);
    rst  = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    // Release falls mid-cycle: IDLE edge, 19 LOAD cycles, sen low after edge 20.
    while (!seen && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (sen === 1'b0) seen = 1'b1;
    end
    chk("first_low_edge", 32'(cyc), 32'd20);
    cyc = 0;
    while (frames_seen < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("frames_done", 32'(frames_seen), 32'd8);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (sen !== 1'b1 || sd !== 1'b0) bad++;
    end
    chk("done_idle", 32'(bad), 32'd0);
    chk("frames_after_done", 32'(frames_seen), 32'd8);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    for (int n = 0; n < 8; n++) begin
      rb2_rd_a = 3'(n);
      @(posedge clk);
      @(negedge clk);
      chk("rb2_word", 32'(rb2_q), 32'(ew[n]));
    end
  endtask

  initial begin
    logic [17:0][7:0] rimg;
    logic [7:0][17:0] rexp;
    int cyc;
    bit reached;

    n_cmp    = 0;
    n_bad    = 0;
    addr_err = 0;
    ctl_err  = 0;
    rst      = 1'b0;
    tb_load  = 1'b0;
    tb_wen   = 1'b1;
    tb_a     = '0;
    tb_d     = '0;
    rb2_rd_a = '0;
    rb2_wa   = '0;
    rb2_wd   = '0;
    rb2_wen  = 1'b1;

    for (int k = 0; k < 18; k++) begin
      vecs[0].img[k] = (k % 2 == 0) ? 8'hFF : 8'h00;
      vecs[2].img[k] = 8'hFF;
      vecs[4].img[k] = 8'h0F;
    end
    for (int n = 0; n < 8; n++) begin
      vecs[0].exp[n] = 18'h2AAAA;
      vecs[2].exp[n] = 18'h3FFFF;
      vecs[4].exp[n] = (n < 4) ? 18'h3FFFF : 18'h00000;
    end
    vecs[1].img    = '0;
    vecs[1].img[0] = 8'h01;
    vecs[1].exp    = '0;
    vecs[1].exp[0] = 18'h20000;
    vecs[3].img     = '0;
    vecs[3].img[17] = 8'h80;
    vecs[3].img[5]  = 8'h10;
    vecs[3].exp     = '0;
    vecs[3].exp[7]  = 18'h00001;
    vecs[3].exp[4]  = 18'h01000;

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      chk("rst_sen", 32'(sen), 32'd1);
      chk("rst_sd", 32'(sd), 32'd0);
      chk("rst_rw", 32'(RB1_RW), 32'd1);
      chk("rst_addr", 32'(RB1_A), 32'd0);
    end

    for (int i = 0; i < 5; i++) begin
      load_img(vecs[i].img);
      push_exp(vecs[i].exp);
      run_xfer(vecs[i].exp);
    end

    // Random image through the full loopback.
    for (int k = 0; k < 18; k++) rimg[k] = 8'($urandom_range(0, 255));
    rexp = transpose(rimg);
    load_img(rimg);
    push_exp(rexp);
    run_xfer(rexp);

    // Reset at bit 10 of frame 3, then a clean restart with the same image.
    for (int k = 0; k < 18; k++) rimg[k] = 8'($urandom_range(0, 255));
    rexp = transpose(rimg);
    load_img(rimg);
    push_exp(rexp);
    @(negedge clk);
    rst     = 1'b1;
    cyc     = 0;
    reached = 1'b0;
    while (!reached && cyc < 300) begin
      @(posedge clk);
      cyc++;
      if (frames_seen == 3 && low_cnt == 10) reached = 1'b1;
    end
    chk("midreset_reach", 32'(reached), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midreset_sen", 32'(sen), 32'd1);
    chk("midreset_sd", 32'(sd), 32'd0);
    repeat (2) @(negedge clk);
    push_exp(rexp);
    run_xfer(rexp);

    chk("rb1_addr_range", 32'(addr_err), 32'd0);
    chk("rb1_ctl_static", 32'(ctl_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
